// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register file.
// Frame layout: R/W flag, then address, then data, all MSB first.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

    localparam logic CMD_WRITE   = 1'b1;
    localparam logic CMD_READ    = 1'b0;
    localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a third flop
// used only to detect rising and falling edges of the synced level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES:0] sh_q;
    logic [SYNC_STAGES:0] sh_d;

    always_comb begin
        sh_d = {sh_q[SYNC_STAGES-1:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= {(SYNC_STAGES + 1){RST_VAL}};
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q    = sh_q[SYNC_STAGES-1];
    assign rise = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
    assign fall = ~sh_q[SYNC_STAGES-1] & sh_q[SYNC_STAGES];

endmodule

// File: rtl/spi_slave_regfile.sv
// Oversampled SPI slave (CPOL=0) fronting a register array, plus a
// local port so on-chip logic can read and write the same registers.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 200,
    parameter int CPHA   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_we,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              spi_wr,
    output logic              spi_rd,
    output logic [ADDR_W-1:0] spi_addr,
    output logic              frame_err
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic CPHA_B = (CPHA != 0);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    // Reset asserts at once but releases only after two clean clocks.
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] rst_sync_d;
    logic                   rst_ni;

    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_ni = rst_sync_q[SYNC_STAGES-1];

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_s;
    logic ss_rise;
    logic ss_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_ni),
        .d    (sclk),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst_n(rst_ni),
        .d    (ss_n),
        .q    (ss_s),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // Same depth as the sclk path so MOSI lines up with the detected edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;
    logic                   mosi_s;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic smp_edge;
    logic shf_edge;

    assign smp_edge = CPHA_B ? sclk_fall : sclk_rise;
    assign shf_edge = CPHA_B ? sclk_rise : sclk_fall;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              spi_wr_q, spi_wr_d;
    logic              spi_rd_q, spi_rd_d;
    logic              frame_err_q, frame_err_d;
    logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
    logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
    logic              spi_commit;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        rd_sh_d     = rd_sh_q;
        miso_d      = (state_q == ST_DATA && cmd_q == CMD_READ) ? miso_q : 1'b0;
        miso_oe_d   = ~ss_s;
        spi_wr_d    = 1'b0;
        spi_rd_d    = 1'b0;
        frame_err_d = 1'b0;
        spi_addr_d  = spi_addr_q;
        spi_commit  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (smp_edge) begin
                    cmd_d   = mosi_s;
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (smp_edge) begin
                    addr_sh_d = {addr_sh_q[ADDR_W-2:0], mosi_s};
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                        if (cmd_q == CMD_READ) begin
                            rd_sh_d = in_range(addr_sh_d) ?
                                      regs_q[to_idx(addr_sh_d)] : '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else begin
                    if (shf_edge && cmd_q == CMD_READ) begin
                        miso_d  = rd_sh_q[DATA_W-1];
                        rd_sh_d = {rd_sh_q[DATA_W-2:0], 1'b0};
                    end
                    if (smp_edge) begin
                        data_sh_d = {data_sh_q[DATA_W-2:0], mosi_s};
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            state_d    = ST_DONE;
                            miso_d     = 1'b0;
                            spi_addr_d = addr_sh_q;
                            if (cmd_q == CMD_WRITE) begin
                                spi_commit  = in_range(addr_sh_q);
                                spi_wr_d    = in_range(addr_sh_q);
                                frame_err_d = ~in_range(addr_sh_q);
                            end else begin
                                spi_rd_d    = 1'b1;
                                frame_err_d = ~in_range(addr_sh_q);
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SPI commit is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (loc_we && in_range(loc_addr)) begin
            regs_d[to_idx(loc_addr)] = loc_wdata;
        end
        if (spi_commit) begin
            regs_d[to_idx(addr_sh_q)] = data_sh_d;
        end
    end

    always_comb begin
        loc_rdata_d = in_range(loc_addr) ? regs_q[to_idx(loc_addr)] : '0;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= 1'b0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rd_sh_q     <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            spi_wr_q    <= 1'b0;
            spi_rd_q    <= 1'b0;
            frame_err_q <= 1'b0;
            spi_addr_q  <= '0;
            loc_rdata_q <= '0;
            mosi_sync_q <= '0;
            regs_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            rd_sh_q     <= rd_sh_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            spi_wr_q    <= spi_wr_d;
            spi_rd_q    <= spi_rd_d;
            frame_err_q <= frame_err_d;
            spi_addr_q  <= spi_addr_d;
            loc_rdata_q <= loc_rdata_d;
            mosi_sync_q <= mosi_sync_d;
            regs_q      <= regs_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign spi_wr    = spi_wr_q;
    assign spi_rd    = spi_rd_q;
    assign frame_err = frame_err_q;
    assign spi_addr  = spi_addr_q;
    assign loc_rdata = loc_rdata_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: default 8/8 CPHA=0 instance plus a
// 6-bit address, 16-bit data, CPHA=1 instance sharing sclk/mosi.
module tb_spi_slave_regfile;

    localparam int HALF = 80;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic mosi  = 1'b0;
    logic ss1_n = 1'b1;
    logic ss2_n = 1'b1;

    logic       miso1, oe1, wr1, rd1, err1, lwe1;
    logic [7:0] addr1, la1, lw1, lr1;

    logic        miso2, oe2, wr2, rd2, err2, lwe2;
    logic [5:0]  addr2, la2;
    logic [15:0] lw2, lr2;

    always #5 clk = ~clk;

    spi_slave_regfile dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss1_n),
        .mosi(mosi), .miso(miso1), .miso_oe(oe1),
        .loc_addr(la1), .loc_we(lwe1), .loc_wdata(lw1),
        .loc_rdata(lr1), .spi_wr(wr1), .spi_rd(rd1),
        .spi_addr(addr1), .frame_err(err1)
    );

    spi_slave_regfile #(
        .ADDR_W(6), .DATA_W(16), .DEPTH(40), .CPHA(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss2_n),
        .mosi(mosi), .miso(miso2), .miso_oe(oe2),
        .loc_addr(la2), .loc_we(lwe2), .loc_wdata(lw2),
        .loc_rdata(lr2), .spi_wr(wr2), .spi_rd(rd2),
        .spi_addr(addr2), .frame_err(err2)
    );

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       err;
        logic       ca;
        logic [7:0] addr;
    } ev_t;

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } lv_t;

    ev_t q1[$];
    ev_t q2[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic ev_t ev(input logic wr, input logic rd,
                               input logic err, input logic ca,
                               input logic [7:0] a);
        ev_t e;
        e.wr   = wr;
        e.rd   = rd;
        e.err  = err;
        e.ca   = ca;
        e.addr = a;
        return e;
    endfunction

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (wr1 | rd1 | err1) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected pulse", 32'({wr1, rd1, err1}), 0);
                end else begin
                    e = q1.pop_front();
                    check("dut1 pulse", 32'({wr1, rd1, err1}),
                          32'({e.wr, e.rd, e.err}));
                    if (e.ca) check("dut1 spi_addr", 32'(addr1), 32'(e.addr));
                end
            end
            if (wr2 | rd2 | err2) begin
                if (q2.size() == 0) begin
                    check("dut2 unexpected pulse", 32'({wr2, rd2, err2}), 0);
                end else begin
                    e = q2.pop_front();
                    check("dut2 pulse", 32'({wr2, rd2, err2}),
                          32'({e.wr, e.rd, e.err}));
                    if (e.ca) check("dut2 spi_addr", 32'(addr2), 32'(e.addr));
                end
            end
        end
    endtask

    task automatic spi_frame(input logic sel2, input int nbits,
                             input logic [31:0] bits, input int stop_at,
                             output logic [31:0] rx, output logic oe_all);
        logic b;
        rx     = '0;
        oe_all = 1'b1;
        if (sel2) ss2_n = 1'b0;
        else ss1_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits && i != stop_at; i++) begin
            b = bits[nbits-1-i];
            if (!sel2) begin
                mosi = b;
                #(HALF);
                rx     = {rx[30:0], miso1};
                oe_all = oe_all & oe1;
                sclk   = 1'b1;
                #(HALF);
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                mosi = b;
                #(HALF);
                rx     = {rx[30:0], miso2};
                oe_all = oe_all & oe2;
                sclk   = 1'b0;
                #(HALF);
            end
        end
        #(HALF);
        ss1_n = 1'b1;
        ss2_n = 1'b1;
        mosi  = 1'b0;
        #(2 * HALF);
    endtask

    task automatic loc_chk(input logic [7:0] a, input logic [7:0] exp,
                           input string nm);
        @(negedge clk);
        la1  = a;
        lwe1 = 1'b0;
        @(negedge clk);
        check(nm, 32'(lr1), 32'(exp));
    endtask

    task automatic loc_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        la1  = a;
        lw1  = d;
        lwe1 = 1'b1;
        @(negedge clk);
        lwe1 = 1'b0;
    endtask

    // Local write to la lands on the same clock as the SPI commit to 7.
    task automatic collide(input logic [7:0] la);
        logic [31:0] rx;
        logic        oe;
        q1.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 8'd7));
        fork
            spi_frame(1'b0, 17, {15'd0, 1'b1, 8'd7, 8'hAA}, -1, rx, oe);
            begin
                la1 = la;
                lw1 = 8'h55;
                repeat (17) @(posedge sclk);
                #20;
                lwe1 = 1'b1;
                #10;
                lwe1 = 1'b0;
            end
        join
    endtask

    lv_t         vec[9];
    logic [31:0] rx;
    logic        oe;

    initial begin
        vec[0] = '{1'b1, 8'd5,   8'h3C, 8'h00};
        vec[1] = '{1'b0, 8'd5,   8'h00, 8'h3C};
        vec[2] = '{1'b1, 8'd199, 8'hA5, 8'h00};
        vec[3] = '{1'b0, 8'd199, 8'h00, 8'hA5};
        vec[4] = '{1'b1, 8'd200, 8'h77, 8'h00};
        vec[5] = '{1'b0, 8'd200, 8'h00, 8'h00};
        vec[6] = '{1'b1, 8'd255, 8'h12, 8'h00};
        vec[7] = '{1'b0, 8'd255, 8'h00, 8'h00};
        vec[8] = '{1'b0, 8'd5,   8'h00, 8'h3C};

        lwe1 = 1'b0; la1 = '0; lw1 = '0;
        lwe2 = 1'b0; la2 = '0; lw2 = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset dut1 flags", 32'({oe1, miso1, wr1, rd1, err1}), 0);
        check("reset dut1 spi_addr", 32'(addr1), 0);
        check("reset dut1 loc_rdata", 32'(lr1), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            la1  = vec[i].a;
            lw1  = vec[i].d;
            lwe1 = vec[i].we;
            @(negedge clk);
            check($sformatf("loc vec %0d", i), 32'(lr1), 32'(vec[i].exp));
            lwe1 = 1'b0;
        end

        q1.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 8'd171));
        spi_frame(1'b0, 17, {15'd0, 1'b1, 8'd171, 8'hB9}, -1, rx, oe);
        loc_chk(8'd171, 8'hB9, "loc read after spi write 171");

        q1.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 8'd5));
        spi_frame(1'b0, 17, {15'd0, 1'b0, 8'd5, 8'h00}, -1, rx, oe);
        check("spi read 5 data", 32'(rx[7:0]), 32'h3C);
        check("miso_oe during frame", 32'(oe), 1);
        check("miso_oe after frame", 32'(oe1), 0);

        q1.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, 8'd250));
        spi_frame(1'b0, 17, {15'd0, 1'b1, 8'd250, 8'hFF}, -1, rx, oe);
        loc_chk(8'd171, 8'hB9, "reg 171 kept after oor write");
        loc_chk(8'd199, 8'hA5, "reg 199 kept after oor write");
        loc_chk(8'd5, 8'h3C, "reg 5 kept after oor write");
        q1.push_back(ev(1'b0, 1'b1, 1'b1, 1'b1, 8'd250));
        spi_frame(1'b0, 17, {15'd0, 1'b0, 8'd250, 8'h00}, -1, rx, oe);
        check("spi read 250 data", 32'(rx[7:0]), 0);

        q1.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        spi_frame(1'b0, 17, {15'd0, 1'b1, 8'd10, 8'h5A}, 14, rx, oe);
        loc_chk(8'd10, 8'h00, "reg 10 after aborted write");
        q1.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 8'd10));
        spi_frame(1'b0, 17, {15'd0, 1'b1, 8'd10, 8'h5A}, -1, rx, oe);
        loc_chk(8'd10, 8'h5A, "reg 10 after full write");

        collide(8'd7);
        loc_chk(8'd7, 8'hAA, "same-addr collision reg 7");
        loc_wr(8'd7, 8'h00);
        collide(8'd8);
        loc_chk(8'd7, 8'hAA, "diff-addr collision reg 7");
        loc_chk(8'd8, 8'h55, "diff-addr collision reg 8");
        check("dut1 events pending", 32'(q1.size()), 0);

        fork
            spi_frame(1'b0, 17, {15'd0, 1'b1, 8'd20, 8'h33}, -1, rx, oe);
            begin
                #(HALF * 9);
                rst_n = 1'b0;
                #1;
                check("mid-frame reset flags",
                      32'({oe1, miso1, wr1, rd1, err1}), 0);
                check("mid-frame reset spi_addr", 32'(addr1), 0);
                check("mid-frame reset loc_rdata", 32'(lr1), 0);
            end
        join
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        loc_chk(8'd171, 8'h00, "reg 171 after reset");
        loc_chk(8'd8, 8'h00, "reg 8 after reset");
        loc_chk(8'd20, 8'h00, "reg 20 after reset");

        q2.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 8'd3));
        spi_frame(1'b1, 23, {9'd0, 1'b1, 6'd3, 16'hBEEF}, -1, rx, oe);
        q2.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 8'd3));
        spi_frame(1'b1, 23, {9'd0, 1'b0, 6'd3, 16'h0000}, -1, rx, oe);
        check("dut2 read 3 data", 32'(rx[15:0]), 32'hBEEF);
        check("dut2 miso_oe during frame", 32'(oe), 1);
        @(negedge clk);
        la2 = 6'd3;
        @(negedge clk);
        check("dut2 loc read 3", 32'(lr2), 32'hBEEF);
        check("dut2 events pending", 32'(q2.size()), 0);
        check("dut1 events pending at end", 32'(q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
